pipe_skid_stage: RTL and testbench

//  Parametrised pipeline-stage register, successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry_reg.sv | 53 +++++
 rtl/pipe_skid_stage.sv | 156 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared state encoding and bubble constant for pipeline stages.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // A control bundle made entirely of this bit value marks a bubble.
  localparam logic CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : One valid+ctrl+data holding register with load and clear.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so a squash can never leave a live entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= {CTRL_W{CTRL_BUBBLE}};
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= {CTRL_W{CTRL_BUBBLE}};
      if (CLEAR_DATA != 0) begin
        r_data <= '0;
      end
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Valid/ready pipeline stage register with a 2-entry skid buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  localparam logic [1:0] S_EMPTY = PS_EMPTY;
  localparam logic [1:0] S_ONE   = PS_ONE;
  localparam logic [1:0] S_TWO   = PS_TWO;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_drain;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  // Ready depends on state alone so back-pressure never forms a comb loop.
  assign in_ready_o = (r_state != S_TWO);
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_drain    = w_main_valid & out_ready_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (!start_i || flush_i) begin
      w_state_nxt  = S_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_main_load = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_TWO;
            w_skid_load = 1'b1;
          end else if (w_drain) begin
            w_state_nxt  = S_EMPTY;
            w_main_clear = 1'b1;
          end
        end
        S_TWO: begin
          if (w_drain) begin
            w_state_nxt      = S_ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = S_EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : in_ctrl_i;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : in_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  pipe_entry_reg #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_entry_reg #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (in_ctrl_i),
    .i_data  (in_data_i),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  // Skid valid is implied by the TWO state; the flag itself is not needed.
  logic w_unused;
  assign w_unused = w_skid_valid;

  assign out_valid_o = w_main_valid;
  assign out_ctrl_o  = w_main_valid ? w_main_ctrl : {CTRL_W{CTRL_BUBBLE}};
  assign out_data_o  = w_main_data;
  assign occupancy_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Directed self-checking bench for pipe_skid_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_ctrl_i;
  logic [63:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_ctrl_o;
  logic [63:0] out_data_o;
  logic [1:0]  occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_skid_stage #(
    .DATA_W     (64),
    .CTRL_W     (8),
    .CLEAR_DATA (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d);
    in_valid_i = v;
    in_ctrl_i  = c;
    in_data_i  = d;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [7:0] c,
                          input logic [63:0] d, input logic [1:0] occ);
    chk({tag, ".valid"}, {63'd0, out_valid_o}, {63'd0, v});
    chk({tag, ".ctrl"},  {56'd0, out_ctrl_o},  {56'd0, c});
    chk({tag, ".data"},  out_data_o, d);
    chk({tag, ".occ"},   {62'd0, occupancy_o}, {62'd0, occ});
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 8'h00, 64'h0);
    tick(); tick();
    chk_head("reset", 1'b0, 8'h00, 64'h0, 2'd0);
    chk("reset.rdy", {63'd0, in_ready_o}, 64'd1);
    rst_i = 1'b0;

    // Streaming 1..16 back-to-back.
    out_ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 64'(i));
      tick();
      chk_head($sformatf("stream%0d", i), 1'b1, 8'(i), 64'(i), 2'd1);
      chk($sformatf("stream%0d.rdy", i), {63'd0, in_ready_o}, 64'd1);
    end
    drive(1'b0, 8'h00, 64'h0);
    tick();
    chk_head("stream.end", 1'b0, 8'h00, 64'h0, 2'd0);

    // Back-pressure A,B,C.
    out_ready_i = 1'b0;
    drive(1'b1, 8'h0A, 64'hA);
    tick();
    chk_head("bp.A", 1'b1, 8'h0A, 64'hA, 2'd1);
    drive(1'b1, 8'h0B, 64'hB);
    tick();
    chk_head("bp.AB", 1'b1, 8'h0A, 64'hA, 2'd2);
    chk("bp.AB.rdy", {63'd0, in_ready_o}, 64'd0);
    drive(1'b1, 8'h0C, 64'hC);
    tick();
    chk_head("bp.Cwait", 1'b1, 8'h0A, 64'hA, 2'd2);
    chk("bp.Cwait.rdy", {63'd0, in_ready_o}, 64'd0);
    out_ready_i = 1'b1;
    tick();
    chk_head("bp.B", 1'b1, 8'h0B, 64'hB, 2'd1);
    tick();
    chk_head("bp.C", 1'b1, 8'h0C, 64'hC, 2'd1);
    drive(1'b0, 8'h00, 64'h0);
    tick();
    chk_head("bp.end", 1'b0, 8'h00, 64'h0, 2'd0);

    // Flush in TWO with a pending beat.
    out_ready_i = 1'b0;
    drive(1'b1, 8'h31, 64'h31); tick();
    drive(1'b1, 8'h32, 64'h32); tick();
    chk("fl.pre.occ", {62'd0, occupancy_o}, 64'd2);
    drive(1'b1, 8'h33, 64'h33);
    flush_i = 1'b1;
    tick();
    chk_head("fl.two", 1'b0, 8'h00, 64'h0, 2'd0);
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 64'h0);
    tick();
    chk_head("fl.after", 1'b0, 8'h00, 64'h0, 2'd0);

    // Flush in EMPTY with an accepted beat: beat is discarded.
    drive(1'b1, 8'h44, 64'h44);
    flush_i = 1'b1;
    tick();
    chk_head("fl.acc", 1'b0, 8'h00, 64'h0, 2'd0);
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 64'h0);

    // Start gating for three cycles.
    out_ready_i = 1'b1;
    start_i = 1'b0;
    drive(1'b1, 8'hFF, 64'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_head($sformatf("idle%0d", i), 1'b0, 8'h00, 64'h0, 2'd0);
      chk($sformatf("idle%0d.rdy", i), {63'd0, in_ready_o}, 64'd1);
    end
    start_i = 1'b1;
    tick();
    chk_head("start", 1'b1, 8'hFF, 64'h55, 2'd1);

    // Simultaneous accept+drain in ONE.
    drive(1'b1, 8'h11, 64'h111); tick();
    chk_head("ad.11", 1'b1, 8'h11, 64'h111, 2'd1);
    drive(1'b1, 8'h22, 64'h222); tick();
    chk_head("ad.22", 1'b1, 8'h22, 64'h222, 2'd1);
    drive(1'b0, 8'h00, 64'h0); tick();
    chk_head("ad.end", 1'b0, 8'h00, 64'h0, 2'd0);

    // Asynchronous reset while holding two entries.
    out_ready_i = 1'b0;
    drive(1'b1, 8'h61, 64'h61); tick();
    drive(1'b1, 8'h62, 64'h62); tick();
    chk("ar.pre.occ", {62'd0, occupancy_o}, 64'd2);
    drive(1'b0, 8'h00, 64'h0);
    #2 rst_i = 1'b1;
    #1;
    chk_head("ar", 1'b0, 8'h00, 64'h0, 2'd0);
    chk("ar.rdy", {63'd0, in_ready_o}, 64'd1);
    tick();
    rst_i = 1'b0;
    tick();
    chk_head("ar.after", 1'b0, 8'h00, 64'h0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
